// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer: OPMODE fields, FSM states, defaults.
package dsp_mac_sequencer_pkg;

  localparam int unsigned DSP_LAT_DEFAULT = 4;

  localparam logic [1:0] OPM_X_ZERO = 2'd0;
  localparam logic [1:0] OPM_X_M    = 2'd1;
  localparam logic [1:0] OPM_X_P    = 2'd2;
  localparam logic [1:0] OPM_X_DAB  = 2'd3;

  localparam logic [1:0] OPM_Z_ZERO = 2'd0;
  localparam logic [1:0] OPM_Z_PCIN = 2'd1;
  localparam logic [1:0] OPM_Z_P    = 2'd2;
  localparam logic [1:0] OPM_Z_C    = 2'd3;

  localparam int unsigned PREADD_EN   = 4;
  localparam int unsigned CIN_SEL     = 5;
  localparam int unsigned PREADD_SUB  = 6;
  localparam int unsigned POSTADD_SUB = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DRAIN,
    ST_HOLD
  } seq_state_e;

  // Pre-adder off, post-adder adding, carry-in from bit 5 = 0.
  function automatic logic [7:0] opm(input logic [1:0] x, input logic [1:0] z);
    logic [7:0] o;
    o              = '0;
    o[1:0]         = x;
    o[3:2]         = z;
    o[PREADD_EN]   = 1'b0;
    o[CIN_SEL]     = 1'b0;
    o[PREADD_SUB]  = 1'b0;
    o[POSTADD_SUB] = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand-in / result-out handshake bundle; slave = sequencer side, master = producer/consumer side.
interface dsp_mac_sequencer_if;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_a;
  logic [17:0] s_b;
  logic        s_last;
  logic        m_valid;
  logic        m_ready;
  logic [47:0] m_data;
  logic        m_carry;

  modport master (
    output s_valid, s_a, s_b, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_carry
  );

  modport slave (
    input  s_valid, s_a, s_b, s_last, m_ready,
    output s_ready, m_valid, m_data, m_carry
  );
endinterface

// File: rtl/dsp_mac_sequencer_opmode_delay.sv
// dsp_opmode_delay: OPM_DLY-deep 8-bit shift line realigning OPMODE with the M stage; wire at 0.
module dsp_opmode_delay #(
  parameter int unsigned OPM_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opm_in,
  output logic [7:0] opm_out
);
  generate
    if (OPM_DLY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign opm_out = opm_in;
    end else begin : g_line
      logic [7:0] line [OPM_DLY];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned i = 0; i < OPM_DLY; i++) line[i] <= '0;
        end else begin
          line[0] <= opm_in;
          for (int unsigned i = 1; i < OPM_DLY; i++) line[i] <= line[i-1];
        end
      end
      assign opm_out = line[OPM_DLY-1];
    end
  endgenerate
endmodule

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds a DSP48A1 slice with signed 18x18 pairs and returns sum(a*b) from P.
// Build option DSP_MAC_ROUND_EN: the first beat adds ROUND_BIAS through C (X=M, Z=C).
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int unsigned DSP_LAT    = DSP_LAT_DEFAULT,
  parameter int unsigned OPM_DLY    = 2,
  parameter logic [47:0] ROUND_BIAS = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  dsp_mac_sequencer_if.slave bus,
  output logic [17:0]        dsp_a,
  output logic [17:0]        dsp_b,
  output logic [17:0]        dsp_d,
  output logic [47:0]        dsp_c,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_ce,
  output logic               dsp_rst,
  output logic               dsp_carryin,
  input  logic [47:0]        dsp_p,
  input  logic               dsp_carryout
);
  localparam int unsigned CW = $clog2(DSP_LAT + 2);
  localparam logic [7:0] OPM_ACC  = opm(OPM_X_M, OPM_Z_P);
  localparam logic [7:0] OPM_IDLE = opm(OPM_X_ZERO, OPM_Z_P);
`ifdef DSP_MAC_ROUND_EN
  localparam logic [7:0] OPM_FIRST = opm(OPM_X_M, OPM_Z_C);
`else
  localparam logic [7:0] OPM_FIRST = opm(OPM_X_M, OPM_Z_ZERO);
`endif

  seq_state_e    state, state_nxt;
  logic          ready, accept, capture;
  logic [CW-1:0] cnt;
  logic [7:0]    opm_launch;

  assign dsp_d       = '0;
  assign dsp_carryin = 1'b0;
  assign bus.s_ready = ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    bus.m_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        ready  = !dsp_rst;
        accept = bus.s_valid && ready;
        if (accept) state_nxt = bus.s_last ? ST_DRAIN : ST_ACC;
      end
      ST_ACC: begin
        ready  = 1'b1;
        accept = bus.s_valid;
        if (accept && bus.s_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt == CW'(DSP_LAT)) begin
          capture   = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        bus.m_valid = 1'b1;
        if (bus.m_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Every cycle launches something: a beat, an adding bubble (ACC) or a P-hold (elsewhere).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dsp_rst     <= 1'b1;
      dsp_ce      <= 1'b0;
      dsp_a       <= '0;
      dsp_b       <= '0;
      opm_launch  <= '0;
      cnt         <= '0;
      bus.m_data  <= '0;
      bus.m_carry <= 1'b0;
    end else begin
      dsp_rst <= 1'b0;
      dsp_ce  <= 1'b1;
      if (accept) begin
        dsp_a      <= bus.s_a;
        dsp_b      <= bus.s_b;
        opm_launch <= (state == ST_IDLE) ? OPM_FIRST : OPM_ACC;
      end else begin
        dsp_a      <= '0;
        dsp_b      <= '0;
        opm_launch <= (state == ST_ACC) ? OPM_ACC : OPM_IDLE;
      end
      cnt <= (state == ST_DRAIN) ? cnt + 1'b1 : '0;
      if (capture) begin
        bus.m_data  <= dsp_p;
        bus.m_carry <= dsp_carryout;
      end
    end
  end

`ifdef DSP_MAC_ROUND_EN
  // C is only selected by the first-beat opmode, so holding the bias is harmless.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                           dsp_c <= '0;
    else if (accept && state == ST_IDLE)  dsp_c <= ROUND_BIAS;
  end
`else
  logic [47:0] unused_bias;
  assign unused_bias = ROUND_BIAS;
  assign dsp_c       = '0;
`endif

  dsp_opmode_delay #(.OPM_DLY(OPM_DLY)) u_opm_dly (
    .clk     (CLK),
    .rst_n   (RST_N),
    .opm_in  (opm_launch),
    .opm_out (dsp_opmode)
  );
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural DSP48A1 slice; results checked against sum(a*b).
module tb_dsp_mac_sequencer;
  import dsp_mac_sequencer_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int unsigned DLY = 2;
`ifdef DSP_MAC_ROUND_EN
  localparam logic [47:0] BIAS = 48'd8;
`else
  localparam logic [47:0] BIAS = 48'd0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [17:0] dsp_a, dsp_b, dsp_d;
  logic [47:0] dsp_c, dsp_p;
  logic [7:0]  dsp_opmode;
  logic        dsp_ce, dsp_rst, dsp_carryin, dsp_carryout;

  dsp_mac_sequencer_if bus();

  dsp_mac_sequencer #(.DSP_LAT(LAT), .OPM_DLY(DLY), .ROUND_BIAS(BIAS)) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_d(dsp_d), .dsp_c(dsp_c),
    .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
    .dsp_carryin(dsp_carryin), .dsp_p(dsp_p), .dsp_carryout(dsp_carryout)
  );

  always #5 CLK = ~CLK;

  // Slice model: A0/A1, B0/B1, M, OPMODE, C and P/CARRYOUT registers, all CE driven by dsp_ce.
  logic [17:0]        a0, a1, b0, b1;
  logic [47:0]        m_r, c_r, p_r, xmux, zmux;
  logic [7:0]         opm_r;
  logic               co_r;
  logic signed [35:0] prod;
  logic [48:0]        post;

  assign prod = $signed(a1) * $signed(b1);

  always_comb begin
    case (opm_r[1:0])
      OPM_X_M:    xmux = m_r;
      OPM_X_P:    xmux = p_r;
      OPM_X_DAB:  xmux = {dsp_d[11:0], a1, b1};
      default:    xmux = '0;
    endcase
    case (opm_r[3:2])
      OPM_Z_P:    zmux = p_r;
      OPM_Z_C:    zmux = c_r;
      OPM_Z_PCIN, OPM_Z_ZERO: zmux = '0;
      default:    zmux = '0;
    endcase
    post = opm_r[POSTADD_SUB] ? ({1'b0, zmux} - {1'b0, xmux}) : ({1'b0, zmux} + {1'b0, xmux});
  end

  always_ff @(posedge CLK) begin
    if (dsp_rst) begin
      a0 <= '0; a1 <= '0; b0 <= '0; b1 <= '0;
      m_r <= '0; c_r <= '0; p_r <= '0; opm_r <= '0; co_r <= 1'b0;
    end else if (dsp_ce) begin
      a0 <= dsp_a; a1 <= a0;
      b0 <= dsp_b; b1 <= b0;
      m_r   <= {{12{prod[35]}}, prod};
      c_r   <= dsp_c;
      opm_r <= dsp_opmode;
      p_r   <= post[47:0];
      co_r  <= post[48];
    end
  end
  assign dsp_p        = p_r;
  assign dsp_carryout = co_r;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry of the final addition, (BIAS + sum a*b) mod 2^48}.
  logic [17:0] ja[$];
  logic [17:0] jb[$];

  function automatic logic [48:0] ref_job();
    logic [47:0] acc;
    logic [48:0] last_add;
    longint      pr;
    acc      = BIAS;
    last_add = '0;
    foreach (ja[k]) begin
      pr       = longint'($signed(ja[k])) * longint'($signed(jb[k]));
      last_add = {1'b0, acc} + {1'b0, 48'(pr)};
      acc      = last_add[47:0];
    end
    return last_add;
  endfunction

  task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last);
    int unsigned n;
    n = 0;
    bus.s_valid = 1'b1; bus.s_a = a; bus.s_b = b; bus.s_last = last;
    while (!bus.s_ready && n < 50) begin @(negedge CLK); n++; end
    if (!bus.s_ready) check_eq("s_ready_timeout", 0, 1);
    @(negedge CLK);
    bus.s_valid = 1'b0;
  endtask

  task automatic run_job(input string tag, input int unsigned gap1, input bit rnd_gaps,
                         input int unsigned hold);
    logic [48:0] exp;
    int unsigned n, g;
    exp = ref_job();
    bus.m_ready = 1'b0;
    foreach (ja[k]) begin
      g = rnd_gaps ? $urandom_range(2, 0) : ((k == 1) ? gap1 : 0);
      if (k > 0) repeat (g) @(negedge CLK);
      send_beat(ja[k], jb[k], k == ja.size() - 1);
    end
    n = 0;
    while (!bus.m_valid && n < 100) begin @(negedge CLK); n++; end
    if (!bus.m_valid) begin
      check_eq({tag, "_timeout"}, 0, 1);
      return;
    end
    check_eq({tag, "_lat"},   64'(n), 64'(LAT + 1));
    check_eq({tag, "_data"},  bus.m_data, exp[47:0]);
    check_eq({tag, "_carry"}, bus.m_carry, exp[48]);
    repeat (hold) begin
      @(negedge CLK);
      check_eq({tag, "_hold_valid"}, bus.m_valid, 1);
      check_eq({tag, "_hold_data"},  bus.m_data, exp[47:0]);
      check_eq({tag, "_hold_sready"}, bus.s_ready, 0);
    end
    bus.m_ready = 1'b1;
    @(negedge CLK);
    bus.m_ready = 1'b0;
    check_eq({tag, "_mvalid_drop"}, bus.m_valid, 0);
    check_eq({tag, "_sready_after"}, bus.s_ready, 1);
  endtask

  initial begin
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check_eq("rst_sready", bus.s_ready, 0);
    check_eq("rst_mvalid", bus.m_valid, 0);
    check_eq("rst_mdata",  bus.m_data, 0);
    check_eq("rst_dsprst", dsp_rst, 1);
    check_eq("rst_dspce",  dsp_ce, 0);
    check_eq("rst_opmode", dsp_opmode, 0);
    RST_N = 1'b1;
    #1;
    check_eq("post_rst_dsprst_hold", dsp_rst, 1);
    check_eq("post_rst_sready_hold", bus.s_ready, 0);
    @(negedge CLK);
    check_eq("post_rst_dsprst", dsp_rst, 0);
    check_eq("post_rst_ce",     dsp_ce, 1);
    check_eq("post_rst_sready", bus.s_ready, 1);
    check_eq("tie_d_cin",       {dsp_d, dsp_carryin}, 0);

    ja = '{18'd2, 18'd4, 18'd6}; jb = '{18'd3, 18'd5, 18'd7};
    run_job("seq3", 0, 1'b0, 0);
    check_eq("seq3_value", bus.m_data, 48'h44 + BIAS);
    run_job("gap2", 2, 1'b0, 0);
    check_eq("gap2_value", bus.m_data, 48'h44 + BIAS);
    run_job("hold5", 0, 1'b0, 5);

    ja = '{18'h3FFFF}; jb = '{18'd1};
    run_job("single", 0, 1'b0, 0);
    check_eq("single_value", bus.m_data, 48'hFFFF_FFFF_FFFF + BIAS);

    for (int j = 0; j < 25; j++) begin
      ja.delete(); jb.delete();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
        ja.push_back(18'($urandom));
        jb.push_back(18'($urandom));
      end
      run_job("rnd", 0, 1'b1, $urandom_range(3, 0));
    end

    send_beat(18'd5, 18'd5, 1'b0);
    send_beat(18'd7, 18'd7, 1'b0);
    RST_N = 1'b0;
    #1;
    check_eq("midrst_sready", bus.s_ready, 0);
    check_eq("midrst_mvalid", bus.m_valid, 0);
    check_eq("midrst_mdata",  bus.m_data, 0);
    check_eq("midrst_dsprst", dsp_rst, 1);
    check_eq("midrst_dspa",   dsp_a, 0);
    check_eq("midrst_opmode", dsp_opmode, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    ja = '{18'd2}; jb = '{18'd3};
    run_job("post_midrst", 0, 1'b0, 0);
    check_eq("post_midrst_value", bus.m_data, 48'd6 + BIAS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
